// File: rtl/ps2_key_pad_pkg.sv
// ps2_key_pad_pkg: button indices, scancode map and repeat states for ps2_key_pad
package ps2_key_pad_pkg;

   typedef enum logic [2:0] {
      BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_JUMP, BTN_ACTION, BTN_START, BTN_SELECT
   } btn_e;

   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_e;

   // {extended, scancode}
   localparam logic [8:0] SC_UP     = 9'h175;
   localparam logic [8:0] SC_DOWN   = 9'h172;
   localparam logic [8:0] SC_LEFT   = 9'h16B;
   localparam logic [8:0] SC_RIGHT  = 9'h174;
   localparam logic [8:0] SC_JUMP   = 9'h029;
   localparam logic [8:0] SC_ACTION = 9'h014;
   localparam logic [8:0] SC_START  = 9'h05A;
   localparam logic [8:0] SC_SELECT = 9'h076;

   // cycles for a millisecond interval; divide first so 50 MHz * 400 ms stays in 32 bits
   function automatic int ms_to_cyc(input int hz, input int ms);
      return (hz / 1000) * ms;
   endfunction

   // returns {hit, button index}; the extended bit must match exactly
   function automatic logic [3:0] key_map(input logic [8:0] k);
      case (k)
         SC_UP:     return {1'b1, BTN_UP};
         SC_DOWN:   return {1'b1, BTN_DOWN};
         SC_LEFT:   return {1'b1, BTN_LEFT};
         SC_RIGHT:  return {1'b1, BTN_RIGHT};
         SC_JUMP:   return {1'b1, BTN_JUMP};
         SC_ACTION: return {1'b1, BTN_ACTION};
         SC_START:  return {1'b1, BTN_START};
         SC_SELECT: return {1'b1, BTN_SELECT};
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/ps2_key_pad_repeat.sv
// ps2_key_pad_repeat: auto-repeat FSM for the most recently pressed direction
module ps2_key_pad_repeat
   import ps2_key_pad_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int REPEAT_DELAY_MS = 400,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] dir_press,
   input  logic [3:0] dir_held,
   output logic [3:0] rep
);
   localparam int DLY = ms_to_cyc(CLK_HZ, REPEAT_DELAY_MS);
   localparam int RATE = ms_to_cyc(CLK_HZ, REPEAT_RATE_MS);
   localparam int CW = $clog2((DLY > RATE ? DLY : RATE) + 1) + 1;
   rep_state_e state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0] sel, sel_nx;
   // state, countdown and target direction registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= R_IDLE;
         cnt <= '0;
         sel <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         sel <= sel_nx;
      end
   // counter loads one less than the interval so the pulse lands exactly on the interval
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      sel_nx = sel;
      rep = '0;
      if (|dir_press) begin
         state_nx = R_DELAY;
         cnt_nx = CW'(DLY - 1);
         sel_nx = dir_press[3] ? 2'd3 : dir_press[2] ? 2'd2 : dir_press[1] ? 2'd1 : 2'd0;
      end else if (state != R_IDLE && !dir_held[sel]) begin
         state_nx = R_IDLE;
      end else if (state != R_IDLE) begin
         if (cnt == '0) begin
            rep[sel] = 1'b1;
            cnt_nx = CW'(RATE - 1);
            state_nx = R_REPEAT;
         end else begin
            cnt_nx = cnt - 1'b1;
         end
      end
   end
endmodule

// File: rtl/ps2_key_pad.sv
// ps2_key_pad: hps_io ps2_key decoder to 8-bit pad with SOCD; PS2_KEY_PAD_REPEAT_EN adds direction auto-repeat
module ps2_key_pad
   import ps2_key_pad_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int REPEAT_DELAY_MS = 400,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   output logic [7:0]  btn_held,
   output logic [7:0]  btn_press,
   output logic [7:0]  btn_release,
   output logic        key_event
);
   logic tog_q, armed, ev, hit, newp;
   logic last_h, last_v, last_h_nx, last_v_nx;
   logic [2:0] idx;
   logic [7:0] raw, raw_nx, held_nx;
   logic [3:0] rep;
   assign ev = armed & (ps2_key[10] != tog_q);
   // next raw state, SOCD winner tracking and resolved held levels
   always_comb begin
      {hit, idx} = key_map(ps2_key[8:0]);
      newp = ev & hit & ps2_key[9] & ~raw[idx];
      raw_nx = raw;
      if (ev && hit) raw_nx[idx] = ps2_key[9];
      last_h_nx = (newp && idx == BTN_LEFT) ? 1'b0 : (newp && idx == BTN_RIGHT) ? 1'b1 : last_h;
      last_v_nx = (newp && idx == BTN_UP) ? 1'b0 : (newp && idx == BTN_DOWN) ? 1'b1 : last_v;
      held_nx = raw_nx;
      if (raw_nx[BTN_LEFT] && raw_nx[BTN_RIGHT]) begin
         held_nx[BTN_LEFT] = ~last_h_nx;
         held_nx[BTN_RIGHT] = last_h_nx;
      end
      if (raw_nx[BTN_UP] && raw_nx[BTN_DOWN]) begin
         held_nx[BTN_UP] = ~last_v_nx;
         held_nx[BTN_DOWN] = last_v_nx;
      end
   end
`ifdef PS2_KEY_PAD_REPEAT_EN
   ps2_key_pad_repeat #(
      .CLK_HZ(CLK_HZ), .REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)
   ) u_repeat (
      .clk(clk), .reset_n(reset_n),
      .dir_press(held_nx[3:0] & ~btn_held[3:0]),
      .dir_held(held_nx[3:0]),
      .rep(rep)
   );
`else
   assign rep = '0;
`endif
   // toggle tracking, raw state and registered outputs
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tog_q <= 1'b0;
         armed <= 1'b0;
         key_event <= 1'b0;
         raw <= '0;
         last_h <= 1'b0;
         last_v <= 1'b0;
         btn_held <= '0;
         btn_press <= '0;
         btn_release <= '0;
      end else begin
         tog_q <= ps2_key[10];
         armed <= 1'b1;
         key_event <= ev;
         raw <= raw_nx;
         last_h <= last_h_nx;
         last_v <= last_v_nx;
         btn_held <= held_nx;
         btn_press <= (held_nx & ~btn_held) | {4'b0, rep};
         btn_release <= btn_held & ~held_nx;
      end
endmodule

// File: tb/tb_ps2_key_pad.sv
// tb_ps2_key_pad: directed self-checking bench for ps2_key_pad; PS2_KEY_PAD_REPEAT_EN enables the repeat scenario
module tb_ps2_key_pad;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [10:0] ps2_key = 11'h400;
   logic [7:0] btn_held, btn_press, btn_release;
   logic key_event;
   int errors = 0;
   int checks = 0;

   ps2_key_pad #(.CLK_HZ(1000), .REPEAT_DELAY_MS(4), .REPEAT_RATE_MS(2)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
      .btn_held(btn_held), .btn_press(btn_press), .btn_release(btn_release),
      .key_event(key_event)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic p, input logic e, input logic [7:0] sc);
      ps2_key = {~ps2_key[10], p, e, sc};
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({btn_held, btn_press, btn_release, key_event} !== 25'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {btn_held, btn_press, btn_release, key_event});
      end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (key_event !== 1'b0 || btn_held !== 8'h00) begin
            errors++;
            $display("FAIL arm_no_event cyc%0d: key_event=%b held=%h expected 0/00", i, key_event, btn_held);
         end
      end
   endtask

   task automatic test_jump();
      send(1'b1, 1'b0, 8'h29);
      checks++;
      if (btn_held !== 8'h10 || btn_press !== 8'h10 || key_event !== 1'b1) begin
         errors++;
         $display("FAIL jump_press: held=%h press=%h ev=%b expected 10/10/1", btn_held, btn_press, key_event);
      end
      tick();
      checks++;
      if (btn_press !== 8'h00 || key_event !== 1'b0 || btn_held !== 8'h10) begin
         errors++;
         $display("FAIL jump_pulse_end: held=%h press=%h ev=%b expected 10/00/0", btn_held, btn_press, key_event);
      end
      send(1'b0, 1'b0, 8'h29);
      checks++;
      if (btn_held !== 8'h00 || btn_release !== 8'h10) begin
         errors++;
         $display("FAIL jump_release: held=%h release=%h expected 00/10", btn_held, btn_release);
      end
   endtask

   task automatic test_socd_lr();
      send(1'b1, 1'b1, 8'h6B);
      checks++;
      if (btn_held !== 8'h04 || btn_press !== 8'h04) begin
         errors++;
         $display("FAIL left_press: held=%h press=%h expected 04/04", btn_held, btn_press);
      end
      send(1'b1, 1'b1, 8'h74);
      checks++;
      if (btn_held !== 8'h08 || btn_release !== 8'h04 || btn_press !== 8'h08) begin
         errors++;
         $display("FAIL socd_right_wins: held=%h release=%h press=%h expected 08/04/08", btn_held, btn_release, btn_press);
      end
      send(1'b0, 1'b1, 8'h74);
      checks++;
      if (btn_held !== 8'h04 || btn_press !== 8'h04 || btn_release !== 8'h08) begin
         errors++;
         $display("FAIL socd_restore_left: held=%h press=%h release=%h expected 04/04/08", btn_held, btn_press, btn_release);
      end
      send(1'b0, 1'b1, 8'h6B);
      checks++;
      if (btn_held !== 8'h00 || btn_release !== 8'h04) begin
         errors++;
         $display("FAIL left_release: held=%h release=%h expected 00/04", btn_held, btn_release);
      end
   endtask

   task automatic test_typematic_unmapped();
      send(1'b1, 1'b0, 8'h5A);
      checks++;
      if (btn_held !== 8'h40 || btn_press !== 8'h40) begin
         errors++;
         $display("FAIL start_press: held=%h press=%h expected 40/40", btn_held, btn_press);
      end
      tick();
      send(1'b1, 1'b0, 8'h5A);
      checks++;
      if (btn_held !== 8'h40 || btn_press !== 8'h00 || key_event !== 1'b1) begin
         errors++;
         $display("FAIL start_typematic: held=%h press=%h ev=%b expected 40/00/1", btn_held, btn_press, key_event);
      end
      send(1'b1, 1'b1, 8'h5A);
      checks++;
      if (btn_held !== 8'h40 || btn_press !== 8'h00 || btn_release !== 8'h00 || key_event !== 1'b1) begin
         errors++;
         $display("FAIL ext_5A_unmapped: held=%h press=%h release=%h ev=%b expected 40/00/00/1", btn_held, btn_press, btn_release, key_event);
      end
      send(1'b1, 1'b1, 8'h29);
      checks++;
      if (btn_held !== 8'h40 || btn_press !== 8'h00 || key_event !== 1'b1) begin
         errors++;
         $display("FAIL ext_29_unmapped: held=%h press=%h ev=%b expected 40/00/1", btn_held, btn_press, key_event);
      end
      send(1'b0, 1'b0, 8'h5A);
      checks++;
      if (btn_held !== 8'h00 || btn_release !== 8'h40) begin
         errors++;
         $display("FAIL start_release: held=%h release=%h expected 00/40", btn_held, btn_release);
      end
   endtask

   task automatic test_back_to_back();
      send(1'b1, 1'b1, 8'h75);
      checks++;
      if (btn_held !== 8'h01 || btn_press !== 8'h01) begin
         errors++;
         $display("FAIL b2b_up: held=%h press=%h expected 01/01", btn_held, btn_press);
      end
      send(1'b1, 1'b1, 8'h72);
      checks++;
      if (btn_held !== 8'h02 || btn_press !== 8'h02 || btn_release !== 8'h01) begin
         errors++;
         $display("FAIL b2b_down_wins: held=%h press=%h release=%h expected 02/02/01", btn_held, btn_press, btn_release);
      end
      send(1'b0, 1'b1, 8'h72);
      checks++;
      if (btn_held !== 8'h01 || btn_press !== 8'h01 || btn_release !== 8'h02) begin
         errors++;
         $display("FAIL b2b_up_restored: held=%h press=%h release=%h expected 01/01/02", btn_held, btn_press, btn_release);
      end
      send(1'b0, 1'b1, 8'h75);
      checks++;
      if (btn_held !== 8'h00 || btn_release !== 8'h01) begin
         errors++;
         $display("FAIL b2b_up_release: held=%h release=%h expected 00/01", btn_held, btn_release);
      end
   endtask

   task automatic test_repeat();
      send(1'b1, 1'b1, 8'h75);
      checks++;
      if (btn_press[0] !== 1'b1) begin
         errors++;
         $display("FAIL repeat_p1: press0=%b expected 1", btn_press[0]);
      end
      for (int k = 2; k <= 10; k++) begin
         tick();
         checks++;
         if (btn_press[0] !== (k == 5 || k == 7 || k == 9)) begin
            errors++;
            $display("FAIL repeat_p%0d: press0=%b expected %b", k, btn_press[0], (k == 5 || k == 7 || k == 9));
         end
      end
      send(1'b0, 1'b1, 8'h75);
      checks++;
      if (btn_release !== 8'h01 || btn_press !== 8'h00) begin
         errors++;
         $display("FAIL repeat_release: release=%h press=%h expected 01/00", btn_release, btn_press);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (btn_press !== 8'h00) begin
            errors++;
            $display("FAIL repeat_stopped cyc%0d: press=%h expected 00", k, btn_press);
         end
      end
   endtask

   task automatic test_mid_reset();
      send(1'b1, 1'b1, 8'h75);
      send(1'b1, 1'b1, 8'h72);
      send(1'b1, 1'b1, 8'h6B);
      send(1'b1, 1'b1, 8'h74);
      checks++;
      if (btn_held !== 8'h0A) begin
         errors++;
         $display("FAIL four_dirs_socd: held=%h expected 0A", btn_held);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({btn_held, btn_press, btn_release, key_event} !== 25'h0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", {btn_held, btn_press, btn_release, key_event});
      end
      tick();
      reset_n = 1'b1;
      tick();
      send(1'b0, 1'b1, 8'h75);
      checks++;
      if (key_event !== 1'b1 || btn_release !== 8'h00 || btn_held !== 8'h00) begin
         errors++;
         $display("FAIL post_reset_break: ev=%b release=%h held=%h expected 1/00/00", key_event, btn_release, btn_held);
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_socd_lr();
      test_typematic_unmapped();
      test_back_to_back();
`ifdef PS2_KEY_PAD_REPEAT_EN
      test_repeat();
`endif
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
